// File: rtl/demux1t2_32_buf.sv
// Buffered 1-to-2 demultiplexer for 32-bit words.
// A single valid/ready input stream is steered by s into one of two channels.
// Each channel owns a show-ahead FIFO of DEPTH entries with its own valid/ready
// output handshake. Full/empty come from an explicit occupancy counter, so the
// pointers never need to be compared.
module demux1t2_32_buf #(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   din,
  input  logic          s,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [31:0]   o0,
  output logic          o0_valid,
  input  logic          o0_ready,
  output logic [31:0]   o1,
  output logic          o1_valid,
  input  logic          o1_ready,
  output logic [AW:0]   cnt0,
  output logic [AW:0]   cnt1
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem0 [DEPTH];
  logic [31:0]   mem1 [DEPTH];
  logic [AW-1:0] wr_ptr0;
  logic [AW-1:0] rd_ptr0;
  logic [AW-1:0] wr_ptr1;
  logic [AW-1:0] rd_ptr1;
  logic          full0;
  logic          full1;
  logic          push0;
  logic          push1;
  logic          pop0;
  logic          pop1;

  // Occupancy update: a simultaneous push and pop leaves the count unchanged.
  function automatic logic [AW:0] next_cnt(input logic [AW:0] cnt,
                                           input logic        push,
                                           input logic        pop);
    logic [AW:0] res;
    res = cnt;
    case ({push, pop})
      2'b10:   res = cnt + (AW+1)'(1);
      2'b01:   res = cnt - (AW+1)'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

  // Pointers wrap naturally because DEPTH is a power of two.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return ptr + AW'(1);
  endfunction

  assign full0 = (cnt0 == FULL_CNT);
  assign full1 = (cnt1 == FULL_CNT);

  // A full channel refuses even when its consumer pops in the same cycle:
  // there is no pass-through path, so in_ready depends only on s and fill state.
  assign in_ready = s ? !full1 : !full0;

  assign push0 = in_valid && in_ready && !s;
  assign push1 = in_valid && in_ready &&  s;

  // Pops are gated by valid, so a request on an empty channel is ignored.
  assign pop0 = o0_valid && o0_ready;
  assign pop1 = o1_valid && o1_ready;

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push0) mem0[wr_ptr0] <= din;
    if (push1) mem1[wr_ptr1] <= din;
  end

  // Pointer and occupancy control; reset discards everything, including any
  // push/pop presented in the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr0 <= '0;
      rd_ptr0 <= '0;
      wr_ptr1 <= '0;
      rd_ptr1 <= '0;
      cnt0    <= '0;
      cnt1    <= '0;
    end else begin
      if (push0) wr_ptr0 <= next_ptr(wr_ptr0);
      if (pop0)  rd_ptr0 <= next_ptr(rd_ptr0);
      if (push1) wr_ptr1 <= next_ptr(wr_ptr1);
      if (pop1)  rd_ptr1 <= next_ptr(rd_ptr1);
      cnt0 <= next_cnt(cnt0, push0, pop0);
      cnt1 <= next_cnt(cnt1, push1, pop1);
    end
  end

  // Show-ahead heads, forced to zero when the channel is empty.
  always_comb begin
    o0_valid = (cnt0 != '0);
    o1_valid = (cnt1 != '0);
    o0       = 32'h0;
    o1       = 32'h0;
    if (o0_valid) o0 = mem0[rd_ptr0];
    if (o1_valid) o1 = mem1[rd_ptr1];
  end

endmodule

// File: tb/tb_demux1t2_32_buf.sv
// Bench for demux1t2_32_buf: directed scenarios plus a randomized run, all
// compared against a queue-based model of the two channels.
module tb_demux1t2_32_buf;

  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        s;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] o0;
  logic        o0_valid;
  logic        o0_ready;
  logic [31:0] o1;
  logic        o1_valid;
  logic        o1_ready;
  logic [AW:0] cnt0;
  logic [AW:0] cnt1;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int checks = 0;
  int errors = 0;

  demux1t2_32_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .s(s), .in_valid(in_valid),
    .in_ready(in_ready), .o0(o0), .o0_valid(o0_valid), .o0_ready(o0_ready),
    .o1(o1), .o1_valid(o1_valid), .o1_ready(o1_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // Advance one clock, updating the reference queues from the inputs as
  // presented before the edge.
  task automatic tick();
    bit p0, p1, u0, u1;
    if (!rst) begin
      q0.delete();
      q1.delete();
    end else begin
      u0 = o0_ready && (q0.size() > 0);
      u1 = o1_ready && (q1.size() > 0);
      p0 = in_valid && !s && (q0.size() < DEPTH);
      p1 = in_valid &&  s && (q1.size() < DEPTH);
      if (u0) void'(q0.pop_front());
      if (u1) void'(q1.pop_front());
      if (p0) q0.push_back(din);
      if (p1) q1.push_back(din);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; o0_ready = 1'b0; o1_ready = 1'b0;
    s = 1'b0; din = 32'h0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; o0_ready = 1'b1; o1_ready = 1'b1;
    s = 1'b0; din = 32'hDEADBEEF;
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++; if (o0 !== 32'h0) begin errors++; $display("FAIL reset_o0 got %h exp %h", o0, 32'h0); end
    checks++; if (o1 !== 32'h0) begin errors++; $display("FAIL reset_o1 got %h exp %h", o1, 32'h0); end
    checks++; if (o0_valid !== 1'b0) begin errors++; $display("FAIL reset_o0_valid got %b exp 0", o0_valid); end
    checks++; if (o1_valid !== 1'b0) begin errors++; $display("FAIL reset_o1_valid got %b exp 0", o1_valid); end
    checks++; if (cnt0 !== 2'd0) begin errors++; $display("FAIL reset_cnt0 got %0d exp 0", cnt0); end
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL reset_cnt1 got %0d exp 0", cnt1); end
    s = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_s0 got %b exp 1", in_ready); end
    s = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_s1 got %b exp 1", in_ready); end
    o0_ready = 1'b0; o1_ready = 1'b0;
  endtask

  task automatic test_steering();
    do_reset();
    in_valid = 1'b1; s = 1'b0; din = 32'h00000000;
    tick();
    s = 1'b1; din = 32'hFFFFFFFF;
    tick();
    in_valid = 1'b0;
    checks++; if (o0 !== 32'h0) begin errors++; $display("FAIL steer_o0 got %h exp %h", o0, 32'h0); end
    checks++; if (o0_valid !== 1'b1) begin errors++; $display("FAIL steer_o0_valid got %b exp 1", o0_valid); end
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL steer_cnt0 got %0d exp 1", cnt0); end
    checks++; if (o1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL steer_o1 got %h exp %h", o1, 32'hFFFFFFFF); end
    checks++; if (o1_valid !== 1'b1) begin errors++; $display("FAIL steer_o1_valid got %b exp 1", o1_valid); end
    checks++; if (cnt1 !== 2'd1) begin errors++; $display("FAIL steer_cnt1 got %0d exp 1", cnt1); end
  endtask

  task automatic test_fill();
    do_reset();
    in_valid = 1'b1; s = 1'b0; din = 32'h11111111;
    tick();
    din = 32'h22222222;
    tick();
    in_valid = 1'b0; s = 1'b0; #1;
    checks++; if (cnt0 !== 2'd2) begin errors++; $display("FAIL fill_cnt0 got %0d exp 2", cnt0); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_s0 got %b exp 0", in_ready); end
    checks++; if (o0 !== 32'h11111111) begin errors++; $display("FAIL fill_head got %h exp %h", o0, 32'h11111111); end
    s = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_s1 got %b exp 1", in_ready); end
    o0_ready = 1'b1;
    tick();
    o0_ready = 1'b0; s = 1'b0; #1;
    checks++; if (o0 !== 32'h22222222) begin errors++; $display("FAIL fill_pop_head got %h exp %h", o0, 32'h22222222); end
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL fill_pop_cnt0 got %0d exp 1", cnt0); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_pop_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_head;
    do_reset();
    in_valid = 1'b1; s = 1'b1; din = 32'h00000055;
    tick();
    o1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = 32'hA0 + 32'(i);
      exp_head = (i == 0) ? 32'h00000055 : 32'hA0 + 32'(i - 1);
      #1;
      checks++; if (o1 !== exp_head) begin errors++; $display("FAIL wrap_head[%0d] got %h exp %h", i, o1, exp_head); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
      checks++; if (cnt1 !== 2'd1) begin errors++; $display("FAIL wrap_cnt1[%0d] got %0d exp 1", i, cnt1); end
    end
    in_valid = 1'b0; o1_ready = 1'b0;
    checks++; if (o1 !== 32'hA7) begin errors++; $display("FAIL wrap_last got %h exp %h", o1, 32'hA7); end
    checks++; if (o1_valid !== 1'b1) begin errors++; $display("FAIL wrap_last_valid got %b exp 1", o1_valid); end
  endtask

  task automatic test_cross();
    do_reset();
    in_valid = 1'b1; s = 1'b0; din = 32'hC0C0C0C0;
    tick();
    din = 32'hC1C1C1C1;
    tick();
    o0_ready = 1'b1; s = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL cross_full_ready got %b exp 0", in_ready); end
    s = 1'b1; din = 32'hD0D0D0D0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cross_ready_s1 got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0; o0_ready = 1'b0;
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL cross_cnt0 got %0d exp 1", cnt0); end
    checks++; if (cnt1 !== 2'd1) begin errors++; $display("FAIL cross_cnt1 got %0d exp 1", cnt1); end
    checks++; if (o0 !== 32'hC1C1C1C1) begin errors++; $display("FAIL cross_o0 got %h exp %h", o0, 32'hC1C1C1C1); end
    checks++; if (o1 !== 32'hD0D0D0D0) begin errors++; $display("FAIL cross_o1 got %h exp %h", o1, 32'hD0D0D0D0); end
    o0_ready = 1'b1; o1_ready = 1'b1;
    tick();
    o0_ready = 1'b0; o1_ready = 1'b0;
    checks++; if (cnt0 !== 2'd0 || cnt1 !== 2'd0) begin errors++; $display("FAIL cross_drain got %0d/%0d exp 0/0", cnt0, cnt1); end
    checks++; if (o0 !== 32'h0) begin errors++; $display("FAIL cross_empty_o0 got %h exp %h", o0, 32'h0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1; s = 1'b0; din = 32'hE0E0E0E0;
    tick();
    s = 1'b1; din = 32'hE1E1E1E1;
    tick();
    s = 1'b0; din = 32'hE2E2E2E2; o0_ready = 1'b1; o1_ready = 1'b1; rst = 1'b0;
    tick();
    rst = 1'b1; in_valid = 1'b0; o0_ready = 1'b0; o1_ready = 1'b0;
    checks++; if (cnt0 !== 2'd0 || cnt1 !== 2'd0) begin errors++; $display("FAIL mid_cnt got %0d/%0d exp 0/0", cnt0, cnt1); end
    checks++; if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b/%b exp 0/0", o0_valid, o1_valid); end
    checks++; if (o0 !== 32'h0 || o1 !== 32'h0) begin errors++; $display("FAIL mid_data got %h/%h exp 0/0", o0, o1); end
    tick();
    checks++; if (o0_valid !== 1'b0 || o1_valid !== 1'b0) begin errors++; $display("FAIL mid_idle_valid got %b/%b exp 0/0", o0_valid, o1_valid); end
    in_valid = 1'b1; s = 1'b0; din = 32'hE3E3E3E3;
    tick();
    in_valid = 1'b0;
    checks++; if (o0 !== 32'hE3E3E3E3) begin errors++; $display("FAIL mid_fresh_o0 got %h exp %h", o0, 32'hE3E3E3E3); end
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL mid_fresh_cnt0 got %0d exp 1", cnt0); end
    checks++; if (o1_valid !== 1'b0) begin errors++; $display("FAIL mid_fresh_o1_valid got %b exp 0", o1_valid); end
  endtask

  task automatic test_random();
    logic        exp_rdy;
    logic [31:0] exp_o0, exp_o1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 49) != 0);
      in_valid = $urandom_range(0, 3) != 0;
      s        = $urandom_range(0, 1);
      din      = $urandom;
      o0_ready = $urandom_range(0, 2) == 0;
      o1_ready = $urandom_range(0, 1);
      #1;
      exp_rdy = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, in_ready, exp_rdy); end
      tick();
      exp_o0 = (q0.size() > 0) ? q0[0] : 32'h0;
      exp_o1 = (q1.size() > 0) ? q1[0] : 32'h0;
      checks++; if (o0 !== exp_o0) begin errors++; $display("FAIL rnd_o0[%0d] got %h exp %h", i, o0, exp_o0); end
      checks++; if (o1 !== exp_o1) begin errors++; $display("FAIL rnd_o1[%0d] got %h exp %h", i, o1, exp_o1); end
      checks++; if (o0_valid !== (q0.size() > 0)) begin errors++; $display("FAIL rnd_o0_valid[%0d] got %b exp %0d", i, o0_valid, q0.size() > 0); end
      checks++; if (o1_valid !== (q1.size() > 0)) begin errors++; $display("FAIL rnd_o1_valid[%0d] got %b exp %0d", i, o1_valid, q1.size() > 0); end
      checks++; if (cnt0 !== (AW+1)'(q0.size())) begin errors++; $display("FAIL rnd_cnt0[%0d] got %0d exp %0d", i, cnt0, q0.size()); end
      checks++; if (cnt1 !== (AW+1)'(q1.size())) begin errors++; $display("FAIL rnd_cnt1[%0d] got %0d exp %0d", i, cnt1, q1.size()); end
    end
    rst = 1'b1; in_valid = 1'b0; o0_ready = 1'b0; o1_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; din = 32'h0; s = 1'b0; in_valid = 1'b0;
    o0_ready = 1'b0; o1_ready = 1'b0;
    test_reset();
    test_steering();
    test_fill();
    test_wrap();
    test_cross();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1t2_32_buf.md
# demux1t2_32_buf

Buffered 1-to-2 demultiplexer for 32-bit words, the write-side counterpart of the 32-bit 2-to-1 data mux in the datapath elements library. A single valid/ready input stream is steered by a select bit into one of two output channels. Each channel owns a small show-ahead FIFO with its own valid/ready handshake. It lets one producer feed two independent consumers, for example splitting a result bus between two sinks, without losing words when a sink stalls.

## Interface
- DEPTH, 2: entries per channel FIFO; power of two, >= 2
- AW, log2(DEPTH): pointer width (derived, not overridden)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk
- din  in  32  input word
- s  in  1  channel select: 0 routes to channel 0, 1 routes to channel 1; sampled with din
- in_valid  in  1  din/s valid this cycle
- in_ready  out  1  selected channel can accept; combinational: !full[s]
- o0  out  32  channel 0 head word; 32'h0 when channel 0 empty
- o0_valid  out  1  channel 0 non-empty
- o0_ready  in  1  channel 0 consumer accepts head
- o1  out  32  channel 1 head word; 32'h0 when channel 1 empty
- o1_valid  out  1  channel 1 non-empty
- o1_ready  in  1  channel 1 consumer accepts head
- cnt0  out  AW+1  channel 0 occupancy, 0..DEPTH
- cnt1  out  AW+1  channel 1 occupancy, 0..DEPTH

## Operation
- Push: in_valid && in_ready at an edge writes din into FIFO[s] at wr_ptr[s]. wr_ptr[s] increments modulo DEPTH and cnt[s] increments.
- Pop: oX_valid && oX_ready at an edge advances rd_ptrX modulo DEPTH and decrements cntX.
- Push and pop on the same channel in the same cycle: both happen and cnt is unchanged. This is legal at any occupancy from 1 to DEPTH-1.
- Full channel: in_ready for that select is 0 even if the consumer pops that cycle. There is no pass-through, and the word is held by the producer.
- Empty channel: there is no bypass. A pop request with oX_valid=0 is ignored and the count never underflows.
- The two channels are fully independent. A push to one channel and a pop from the other in the same cycle both complete.
- in_ready is a function of s and the fill state only. It does not depend on in_valid.
- Data on oX comes from storage at rd_ptrX. It is forced to 32'h0 when cntX == 0.
- Ordering: each channel is strict FIFO. Words are not reordered across channels relative to the select sequence within a channel.

## Timing
- Reset, rst=0 at an edge: all pointers 0, cnt0=cnt1=0, o0_valid=o1_valid=0, o0=o1=32'h0. in_ready=1 for either s. FIFO storage contents are don't-care.
- Reset mid-operation: all buffered words are discarded on that edge, and simultaneous push/pop in that cycle is ignored. Behaviour is identical to reset from idle.
- Latency: a word accepted at edge k appears on oX with oX_valid=1 in the cycle after edge k (1 cycle).
- Throughput: 1 word/cycle per channel in steady state when the consumer keeps oX_ready=1.
- Wrap-around: pointers roll from DEPTH-1 to 0. Full is cnt == DEPTH and empty is cnt == 0, so there is no pointer-compare ambiguity.
- Outputs o0/o1/oX_valid/cntX are registered-state derived. Only in_ready is combinational from the s input.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then rst=1 with no traffic -> o0=o1=32'h0, o0_valid=o1_valid=0, cnt0=cnt1=0, in_ready=1 for s=0 and s=1.
- Basic steering: push 32'h00000000 with s=0, then 32'hFFFFFFFF with s=1, both consumers ready=0 -> o0=32'h0 with o0_valid=1 and cnt0=1; o1=32'hFFFFFFFF with o1_valid=1 and cnt1=1.
- Fill and backpressure (DEPTH=2): push 32'h11111111 and 32'h22222222 to channel 0 with o0_ready=0 -> cnt0=2, in_ready=0 at s=0 and 1 at s=1. Then pop once: o0 goes 32'h11111111 -> 32'h22222222, and in_ready at s=0 returns to 1.
- Simultaneous push/pop with wrap: channel 1 holds 1 word, o1_ready=1, push 8 consecutive words 32'hA0..32'hA7 with s=1 -> cnt1 stays 1 throughout. o1 emits the held word, then 32'hA0..32'hA6 in order, and 32'hA7 remains.
- Cross-channel concurrency: channel 0 full, o0_ready=1, push to s=1 in the same cycle -> cnt0 decrements, cnt1 increments, and no word is lost.
- Reset mid-operation: both channels non-empty, assert rst=0 during a push/pop cycle -> on the next cycle both counts are 0, both valids are 0, both outputs are 32'h0, and earlier words never reappear.
